// File: rtl/pencase_pkg.sv
// Shared coin-pattern definitions for the pen-case transmitter and detector.
// Both ends import this package so the colour/code table exists in one place only.
package pencase_pkg;

   localparam logic [1:0] COLOR_RED  = 2'b01;
   localparam logic [1:0] COLOR_BLUE = 2'b10;

   localparam logic [2:0] CODE_RED_P  = 3'b001;
   localparam logic [2:0] CODE_RED_A  = 3'b110;
   localparam logic [2:0] CODE_BLUE_P = 3'b011;
   localparam logic [2:0] CODE_BLUE_A = 3'b100;
   localparam logic [2:0] CODE_IDLE   = 3'b000;

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_DATA = 2'd1,
      SLOT_GAP  = 2'd2
   } slot_e;

   // Receive-side lookup: frame bits (b2 b1 b0) back to a colour, 00 when no colour.
   function automatic logic [1:0] decode_code(input logic [2:0] code);
      logic [1:0] color;
      color = 2'b00;
      if (code == CODE_RED_P || code == CODE_RED_A)
         color = COLOR_RED;
      else if (code == CODE_BLUE_P || code == CODE_BLUE_A)
         color = COLOR_BLUE;
      return color;
   endfunction

endpackage

// File: rtl/pencase_code_enc.sv
// Combinational colour + alternate-select to 3-bit coin code.
// valid is low for the two unused colour encodings.
module pencase_code_enc
   import pencase_pkg::*;
(
   input  logic [1:0] color,
   input  logic       alt,
   output logic [2:0] code,
   output logic       valid
);

   always_comb begin
      code  = CODE_IDLE;
      valid = 1'b0;
      case (color)
         COLOR_RED: begin
            code  = alt ? CODE_RED_A : CODE_RED_P;
            valid = 1'b1;
         end
         COLOR_BLUE: begin
            code  = alt ? CODE_BLUE_A : CODE_BLUE_P;
            valid = 1'b1;
         end
         default: begin
            code  = CODE_IDLE;
            valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pencase_coin_tx.sv
// Serial coin-pattern transmitter: one-entry request holding register, 3-phase
// frame counter, IDLE/DATA/GAP slot selection and detector resync pulses.
module pencase_coin_tx
   import pencase_pkg::*;
#(
   parameter int GAP_SLOTS   = 0,
   parameter bit SYNC_ON_RST = 1'b1
)
(
   input  logic       clock,
   input  logic       n_rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_color,
   input  logic       req_alt,
   input  logic       resync,
   output logic       coin,
   output logic       start,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int GAP_W = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS + 1) : 1;

   logic [1:0]       phase_reg, phase_next;
   slot_e            slot_reg, slot_next;
   logic [2:0]       frame_reg, frame_next;
   logic             hold_full_reg, hold_full_next;
   logic [2:0]       hold_code_reg, hold_code_next;
   logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
   logic             first_reg;
   logic             coin_reg, start_reg, busy_reg, done_reg, err_reg, ready_reg;

   logic [2:0] enc_code;
   logic       enc_valid;
   logic       xfer, sync_now, wrap;
   logic [1:0] bit_idx;

   pencase_code_enc u_enc (
      .color (req_color),
      .alt   (req_alt),
      .code  (enc_code),
      .valid (enc_valid)
   );

   assign xfer     = req_valid && ready_reg;
   assign sync_now = resync || (SYNC_ON_RST && first_reg);
   assign wrap     = (phase_reg == 2'd2);

   always_comb begin
      phase_next     = wrap ? 2'd0 : phase_reg + 2'd1;
      slot_next      = slot_reg;
      frame_next     = frame_reg;
      gap_cnt_next   = gap_cnt_reg;
      hold_full_next = hold_full_reg;
      hold_code_next = hold_code_reg;

      // A sync cycle parks the counter at phase 2 in an IDLE slot, so the
      // following edge is an ordinary wrap that picks the next slot fresh.
      if (sync_now) begin
         phase_next   = 2'd2;
         slot_next    = SLOT_IDLE;
         frame_next   = CODE_IDLE;
         gap_cnt_next = '0;
      end else if (wrap) begin
         if (hold_full_reg && gap_cnt_reg == '0) begin
            slot_next      = SLOT_DATA;
            frame_next     = hold_code_reg;
            gap_cnt_next   = GAP_W'(GAP_SLOTS);
            hold_full_next = 1'b0;
         end else if (gap_cnt_reg != '0) begin
            slot_next    = SLOT_GAP;
            frame_next   = CODE_IDLE;
            gap_cnt_next = gap_cnt_reg - GAP_W'(1);
         end else begin
            slot_next  = SLOT_IDLE;
            frame_next = CODE_IDLE;
         end
      end

      // Invalid colours complete the handshake but never occupy the register.
      if (xfer && enc_valid) begin
         hold_full_next = 1'b1;
         hold_code_next = enc_code;
      end

      bit_idx = 2'd2 - phase_next;
   end

   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         phase_reg     <= 2'd0;
         slot_reg      <= SLOT_IDLE;
         frame_reg     <= CODE_IDLE;
         hold_full_reg <= 1'b0;
         hold_code_reg <= CODE_IDLE;
         gap_cnt_reg   <= '0;
         first_reg     <= 1'b1;
         coin_reg      <= 1'b0;
         start_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         ready_reg     <= 1'b0;
      end else begin
         phase_reg     <= phase_next;
         slot_reg      <= slot_next;
         frame_reg     <= frame_next;
         hold_full_reg <= hold_full_next;
         hold_code_reg <= hold_code_next;
         gap_cnt_reg   <= gap_cnt_next;
         first_reg     <= 1'b0;
         coin_reg      <= sync_now ? 1'b0 : frame_next[bit_idx];
         start_reg     <= sync_now;
         busy_reg      <= hold_full_next || (slot_next != SLOT_IDLE);
         done_reg      <= !sync_now && wrap && (slot_reg == SLOT_DATA);
         err_reg       <= xfer && !enc_valid;
         ready_reg     <= !hold_full_next;
      end
   end

   assign coin      = coin_reg;
   assign start     = start_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign err       = err_reg;
   assign req_ready = ready_reg;

endmodule

// File: tb/tb_pencase_coin_tx.sv
// Directed bench for pencase_coin_tx: a behavioural detector decodes the coin line
// and checks each decoded colour and done pulse against a scoreboard of accepted requests.
module tb_pencase_coin_tx;

   logic       clock = 1'b0;
   logic       n_rst;
   logic       req_valid, req_alt, resync;
   logic [1:0] req_color;
   logic       req_ready, coin, start, busy, done, err;

   logic       b_valid, b_alt, b_resync;
   logic [1:0] b_color;
   logic       b_ready, b_coin, b_start, b_busy, b_done, b_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] sb_q[$];

   int         det_phase = 0;
   int         cur_phase = 0;
   logic [2:0] det_shift = 3'b000;
   logic       det_pend  = 1'b0;
   logic [1:0] det_color = 2'b00;
   logic [1:0] exp_c;

   always #5 clock = ~clock;

   pencase_coin_tx #(.GAP_SLOTS(0), .SYNC_ON_RST(1'b1)) dut_a (
      .clock     (clock),
      .n_rst     (n_rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_color (req_color),
      .req_alt   (req_alt),
      .resync    (resync),
      .coin      (coin),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   pencase_coin_tx #(.GAP_SLOTS(2), .SYNC_ON_RST(1'b1)) dut_b (
      .clock     (clock),
      .n_rst     (n_rst),
      .req_valid (b_valid),
      .req_ready (b_ready),
      .req_color (b_color),
      .req_alt   (b_alt),
      .resync    (b_resync),
      .coin      (b_coin),
      .start     (b_start),
      .busy      (b_busy),
      .done      (b_done),
      .err       (b_err)
   );

   function automatic logic [1:0] decode(input logic [2:0] s);
      case (s)
         3'b001, 3'b110: decode = 2'b01;
         3'b011, 3'b100: decode = 2'b10;
         default:        decode = 2'b00;
      endcase
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference detector: realigns on start, decodes every third bit.
   always @(negedge clock) begin
      if (!n_rst) begin
         det_phase = 0;
         det_shift = 3'b000;
         det_pend  = 1'b0;
         cur_phase = 0;
      end else begin
         chk("mon_done", int'(done), int'(det_pend));
         if (det_pend) begin
            exp_c = (sb_q.size() > 0) ? sb_q.pop_front() : 2'b00;
            chk("mon_color", int'(det_color), int'(exp_c));
         end
         det_pend = 1'b0;
         if (start) begin
            det_phase = 0;
            det_shift = 3'b000;
            cur_phase = 3;
         end else begin
            cur_phase = det_phase;
            det_shift = {det_shift[1:0], coin};
            if (det_phase == 2) begin
               det_phase = 0;
               det_color = decode(det_shift);
               det_pend  = (det_color != 2'b00);
            end else begin
               det_phase = det_phase + 1;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   // Advance one cycle; a request seen with ready high is recorded and withdrawn.
   task automatic step();
      logic drop;
      drop = 1'b0;
      if (req_valid && req_ready) begin
         if (req_color == 2'b01 || req_color == 2'b10)
            sb_q.push_back(req_color);
         drop = 1'b1;
      end
      tick();
      if (drop) req_valid = 1'b0;
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < 8 && cur_phase != p; i++) step();
      chk("wait_phase", cur_phase, p);
   endtask

   task automatic request(input logic [1:0] c, input logic a);
      req_color = c;
      req_alt   = a;
      req_valid = 1'b1;
   endtask

   task automatic check_bits(input string tag, input logic [2:0] code);
      for (int i = 2; i >= 0; i--) begin
         chk(tag, int'(coin), int'(code[i]));
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  bits2;
      logic [11:0] bits6;
      n_rst = 1'b0;
      req_valid = 1'b0; req_color = 2'b00; req_alt = 1'b0; resync = 1'b0;
      b_valid = 1'b0; b_color = 2'b10; b_alt = 1'b0; b_resync = 1'b0;
      repeat (2) tick();
      chk("rst_coin", int'(coin), 0);
      chk("rst_start", int'(start), 0);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      n_rst = 1'b1;
      step();
      chk("sync_start", int'(start), 1);
      chk("sync_coin", int'(coin), 0);
      chk("sync_ready", int'(req_ready), 1);
      step();
      chk("sync_start_end", int'(start), 0);

      // GAP_SLOTS=2 instance: two queued BLUE/primary requests
      wait_phase(0);
      b_valid = 1'b1;
      chk("t6_ready0", int'(b_ready), 1);
      step();
      wait_phase(0);
      chk("t6_ready1", int'(b_ready), 1);
      bits6 = 12'b011000000011;
      for (int i = 0; i < 12; i++) begin
         chk("t6_coin", int'(b_coin), int'(bits6[11-i]));
         chk("t6_busy", int'(b_busy), 1);
         chk("t6_done", int'(b_done), (i == 3) ? 1 : 0);
         step();
         if (i == 0) b_valid = 1'b0;
      end

      // single RED/primary starting at phase 0
      wait_phase(0);
      request(2'b01, 1'b0);
      step();
      wait_phase(0);
      chk("t1_busy", int'(busy), 1);
      check_bits("t1_coin", 3'b001);
      chk("t1_done", int'(done), 1);
      chk("t1_idle_busy", int'(busy), 0);

      // back-to-back BLUE/alt then RED/alt
      wait_phase(0);
      request(2'b10, 1'b1);
      step();
      request(2'b01, 1'b1);
      wait_phase(0);
      bits2 = 6'b100110;
      for (int i = 0; i < 6; i++) begin
         chk("t2_coin", int'(coin), int'(bits2[5-i]));
         chk("t2_done", int'(done), (i == 3) ? 1 : 0);
         step();
      end
      chk("t2_done_last", int'(done), 1);

      // request arriving mid-frame waits for the next frame boundary
      wait_phase(1);
      request(2'b01, 1'b0);
      step();
      chk("t3_wait_coin", int'(coin), 0);
      chk("t3_wait_done", int'(done), 0);
      step();
      check_bits("t3_coin", 3'b001);
      chk("t3_done", int'(done), 1);

      // invalid colour: err only, no frame
      wait_phase(0);
      request(2'b11, 1'b0);
      step();
      chk("t4_err", int'(err), 1);
      chk("t4_ready", int'(req_ready), 1);
      chk("t4_busy", int'(busy), 0);
      step();
      chk("t4_err_end", int'(err), 0);
      for (int i = 0; i < 4; i++) begin
         chk("t4_coin", int'(coin), 0);
         step();
      end

      // resync during the 2nd bit of a RED frame, held for two cycles
      wait_phase(0);
      request(2'b01, 1'b0);
      step();
      wait_phase(0);
      step();
      resync = 1'b1;
      step();
      chk("t5_start", int'(start), 1);
      chk("t5_coin", int'(coin), 0);
      sb_q.delete();
      step();
      chk("t5_start_rep", int'(start), 1);
      chk("t5_coin_rep", int'(coin), 0);
      resync = 1'b0;
      step();
      chk("t5_start_end", int'(start), 0);
      chk("t5_busy", int'(busy), 0);
      repeat (4) step();
      wait_phase(0);
      request(2'b01, 1'b1);
      step();
      wait_phase(0);
      check_bits("t5_coin_after", 3'b110);
      chk("t5_done_after", int'(done), 1);

      // asynchronous reset in the middle of a frame
      wait_phase(0);
      request(2'b01, 1'b1);
      step();
      wait_phase(0);
      step();
      #2 n_rst = 1'b0;
      #1;
      chk("arst_coin", int'(coin), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_ready", int'(req_ready), 0);
      chk("arst_done", int'(done), 0);
      sb_q.delete();
      tick();
      n_rst = 1'b1;
      step();
      chk("arst_sync_start", int'(start), 1);
      step();
      wait_phase(0);
      request(2'b10, 1'b0);
      step();
      wait_phase(0);
      check_bits("arst_coin_after", 3'b011);
      chk("arst_done_after", int'(done), 1);

      repeat (6) step();
      chk("sb_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
